fir_output_serializer: RTL and testbench

//  Downstream stage of the parallel FIR control unit. Captures the NUM_LANES parallel FP32 filter outputs
//  on the DSP58 result strobe, then streams them one per beat over a valid/ready interface, lane 0 first.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_out_bank.sv | 25 ++
 rtl/fir_output_serializer.sv | 153 +++++++++++++++
 tb/tb_fir_output_serializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, state encoding and flag layout for the FIR output stage.
package fir_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_LANES  = 49;
  localparam int IDX_WIDTH  = 6;

  // Bit positions of the DSP exception flags inside the 3-bit status word
  localparam int IDX_INV = 2;
  localparam int IDX_OVF = 1;
  localparam int IDX_UNF = 0;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_LANES - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Places the three DSP flags at their status-word positions
  function automatic logic [2:0] pack_flags(input logic inv, input logic ovf, input logic unf);
    logic [2:0] f;
    f          = '0;
    f[IDX_INV] = inv;
    f[IDX_OVF] = ovf;
    f[IDX_UNF] = unf;
    return f;
  endfunction

endpackage

// File: rtl/fir_out_bank.sv
// NUM_LANES x DATA_WIDTH sample bank: loads a whole frame at once, reads one lane by index.
module fir_out_bank
  import fir_pkg::*;
(
  input  logic                            clk,
  input  logic                            load,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] din,
  input  logic [IDX_WIDTH-1:0]            rd_idx,
  output logic [DATA_WIDTH-1:0]           rd_data
);

  logic [DATA_WIDTH-1:0] mem [NUM_LANES];

  // Capture every lane of the flattened input frame when load is asserted
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        mem[k] <= din[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fir_output_serializer.sv
// Captures NUM_LANES parallel FP32 FIR results on the capture strobe and streams them
// lane 0 first over valid/ready, with per-frame sticky DSP exception flags.
// Optional build macro FIR_OUT_DOUBLE_BUF_EN adds a second (pending) bank so a capture
// arriving mid-stream is queued instead of dropped. rst_n is synchronous and active-high.
module fir_output_serializer
  import fir_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            capture_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] y_i,
  input  logic                            invalid_i,
  input  logic                            overflow_i,
  input  logic                            underflow_i,
  input  logic                            y_ready_i,
  output logic [DATA_WIDTH-1:0]           y_o,
  output logic                            y_valid_o,
  output logic [IDX_WIDTH-1:0]            y_idx_o,
  output logic                            y_last_o,
  output logic [2:0]                      status_o,
  output logic                            busy_o,
  output logic                            overrun_o
);

  state_t                 state;
  logic [IDX_WIDTH-1:0]   idx;
  logic [2:0]             status;
  logic                   overrun;
  logic [2:0]             flags;
  logic                   streaming;
  logic                   last_beat;
  logic                   load_act;
  logic                   drop;
  logic [DATA_WIDTH-1:0]  rd_data;

  assign flags     = pack_flags(invalid_i, overflow_i, underflow_i);
  assign streaming = (state == ST_STREAM);
  assign last_beat = streaming && y_ready_i && (idx == LAST_IDX);
  // The active bank reloads from idle, or back-to-back on the final handshake
  assign load_act  = capture_i && (!streaming || last_beat);

`ifdef FIR_OUT_DOUBLE_BUF_EN
  logic                  sel;
  logic                  pend_full;
  logic [2:0]            pend_status;
  logic                  load_alt;
  logic                  load0;
  logic                  load1;
  logic [DATA_WIDTH-1:0] rd0;
  logic [DATA_WIDTH-1:0] rd1;

  // Ping-pong banks: "promoting" the pending frame is just flipping sel
  assign load_alt = capture_i && streaming && !last_beat && !pend_full;
  assign drop     = capture_i && streaming && !last_beat && pend_full;
  assign load0    = sel ? load_alt : load_act;
  assign load1    = sel ? load_act : load_alt;
  assign rd_data  = sel ? rd1 : rd0;

  fir_out_bank u_bank0 (
    .clk     (clk),
    .load    (load0),
    .din     (y_i),
    .rd_idx  (idx),
    .rd_data (rd0)
  );

  fir_out_bank u_bank1 (
    .clk     (clk),
    .load    (load1),
    .din     (y_i),
    .rd_idx  (idx),
    .rd_data (rd1)
  );
`else
  assign drop = capture_i && streaming && !last_beat;

  fir_out_bank u_bank (
    .clk     (clk),
    .load    (load_act),
    .din     (y_i),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );
`endif

  // Frame sequencing: capture, per-beat index advance, sticky flags and overrun pulse
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      status  <= '0;
      overrun <= 1'b0;
`ifdef FIR_OUT_DOUBLE_BUF_EN
      sel         <= 1'b0;
      pend_full   <= 1'b0;
      pend_status <= '0;
`endif
    end else begin
      overrun <= drop;
      case (state)
        ST_IDLE: begin
          if (capture_i) begin
            state  <= ST_STREAM;
            idx    <= '0;
            status <= flags;
          end
        end
        ST_STREAM: begin
          status <= status | flags;
          if (y_ready_i) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
`ifdef FIR_OUT_DOUBLE_BUF_EN
              if (pend_full) begin
                sel    <= ~sel;
                status <= pend_status;
                if (capture_i) begin
                  pend_status <= flags;
                end else begin
                  pend_full <= 1'b0;
                end
              end else
`endif
              if (capture_i) begin
                status <= flags;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              idx <= idx + IDX_WIDTH'(1);
            end
          end
`ifdef FIR_OUT_DOUBLE_BUF_EN
          if (load_alt) begin
            pend_full   <= 1'b1;
            pend_status <= flags;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign y_valid_o = streaming;
  assign busy_o    = streaming;
  assign y_idx_o   = idx;
  assign y_last_o  = streaming && (idx == LAST_IDX);
  assign y_o       = streaming ? rd_data : '0;
  assign status_o  = status;
  assign overrun_o = overrun;

endmodule

// File: tb/tb_fir_output_serializer.sv
// Directed self-checking bench for fir_output_serializer (vector table plus multi-cycle sequences).
module tb_fir_output_serializer;
  import fir_pkg::*;

  localparam logic [31:0] BASE_A = 32'h3F800000;
  localparam logic [31:0] BASE_B = 32'h40000000;
`ifdef FIR_OUT_DOUBLE_BUF_EN
  localparam bit DOUBLE = 1'b1;
`else
  localparam bit DOUBLE = 1'b0;
`endif

  typedef struct {
    logic        care;
    logic        valid;
    logic [5:0]  idx;
    logic        last;
    logic [31:0] y;
    logic [2:0]  status;
    logic        busy;
    logic        overrun;
  } out_t;

  typedef struct {
    bit          rst;
    bit          cap;
    bit          rdy;
    logic [31:0] base;
    logic [2:0]  flags;
    out_t        exp;
  } vec_t;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b1;
  logic                            capture_i = 1'b0;
  logic [NUM_LANES*DATA_WIDTH-1:0] y_i = '0;
  logic                            invalid_i = 1'b0;
  logic                            overflow_i = 1'b0;
  logic                            underflow_i = 1'b0;
  logic                            y_ready_i = 1'b0;
  logic [DATA_WIDTH-1:0]           y_o;
  logic                            y_valid_o;
  logic [IDX_WIDTH-1:0]            y_idx_o;
  logic                            y_last_o;
  logic [2:0]                      status_o;
  logic                            busy_o;
  logic                            overrun_o;

  int checks = 0;
  int failures = 0;

  fir_output_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture_i   (capture_i),
    .y_i         (y_i),
    .invalid_i   (invalid_i),
    .overflow_i  (overflow_i),
    .underflow_i (underflow_i),
    .y_ready_i   (y_ready_i),
    .y_o         (y_o),
    .y_valid_o   (y_valid_o),
    .y_idx_o     (y_idx_o),
    .y_last_o    (y_last_o),
    .status_o    (status_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic out_t beat(input logic [31:0] base, input int i, input logic [2:0] st, input logic ovr);
    out_t o;
    o.care    = 1'b1;
    o.valid   = 1'b1;
    o.idx     = 6'(i);
    o.last    = (i == NUM_LANES - 1);
    o.y       = base + 32'(i);
    o.status  = st;
    o.busy    = 1'b1;
    o.overrun = ovr;
    return o;
  endfunction

  function automatic out_t idleOut(input logic care, input logic [2:0] st);
    out_t o;
    o.care    = care;
    o.valid   = 1'b0;
    o.idx     = '0;
    o.last    = 1'b0;
    o.y       = '0;
    o.status  = st;
    o.busy    = 1'b0;
    o.overrun = 1'b0;
    return o;
  endfunction

  function automatic vec_t mkVec(input bit rst, input bit cap, input bit rdy, input logic [31:0] base,
                                 input logic [2:0] flags, input out_t exp);
    vec_t v;
    v.rst   = rst;
    v.cap   = cap;
    v.rdy   = rdy;
    v.base  = base;
    v.flags = flags;
    v.exp   = exp;
    return v;
  endfunction

  task automatic applyStimulus(input bit rst, input bit cap, input bit rdy, input logic [31:0] base,
                               input logic [2:0] flags);
    rst_n     = rst;
    capture_i = cap;
    y_ready_i = rdy;
    for (int k = 0; k < NUM_LANES; k++) begin
      y_i[k*DATA_WIDTH +: DATA_WIDTH] = base + 32'(k);
    end
    invalid_i   = flags[2];
    overflow_i  = flags[1];
    underflow_i = flags[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    bit bad;
    checks++;
    bad = (y_valid_o !== exp.valid) || (y_last_o !== exp.last) || (status_o !== exp.status) ||
          (busy_o !== exp.busy) || (overrun_o !== exp.overrun) ||
          (exp.care && ((y_idx_o !== exp.idx) || (y_o !== exp.y)));
    if (bad) begin
      failures++;
      $display("[TB] FAIL %s: got valid=%0b idx=%0d last=%0b y=%h status=%b busy=%0b overrun=%0b, want valid=%0b idx=%0d last=%0b y=%h status=%b busy=%0b overrun=%0b",
               name, y_valid_o, y_idx_o, y_last_o, y_o, status_o, busy_o, overrun_o,
               exp.valid, exp.idx, exp.last, exp.y, exp.status, exp.busy, exp.overrun);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
  endtask

  // Stimulus and checking
  initial begin
    vec_t        tbl[10];
    logic [5:0]  exp_idx;
    bit          exp_valid;
    bit          r;
    int          cyc;

    // Cycle-by-cycle vectors: reset, capture, stall, flag accumulation, mid-stream capture, reset again
    tbl[0] = mkVec(1, 0, 0, BASE_A, 3'b000, idleOut(1'b1, 3'b000));
    tbl[1] = mkVec(0, 1, 0, BASE_A, 3'b010, beat(BASE_A, 0, 3'b010, 1'b0));
    tbl[2] = mkVec(0, 0, 0, BASE_B, 3'b000, beat(BASE_A, 0, 3'b010, 1'b0));
    tbl[3] = mkVec(0, 0, 1, BASE_B, 3'b000, beat(BASE_A, 1, 3'b010, 1'b0));
    tbl[4] = mkVec(0, 0, 1, BASE_B, 3'b100, beat(BASE_A, 2, 3'b110, 1'b0));
    tbl[5] = mkVec(0, 0, 0, BASE_B, 3'b000, beat(BASE_A, 2, 3'b110, 1'b0));
    tbl[6] = mkVec(0, 1, 0, BASE_B, 3'b000, beat(BASE_A, 2, 3'b110, !DOUBLE));
    tbl[7] = mkVec(0, 0, 1, BASE_B, 3'b000, beat(BASE_A, 3, 3'b110, 1'b0));
    tbl[8] = mkVec(1, 0, 1, BASE_B, 3'b000, idleOut(1'b1, 3'b000));
    tbl[9] = mkVec(0, 0, 1, BASE_B, 3'b000, idleOut(1'b1, 3'b000));

    for (int v = 0; v < 10; v++) begin
      applyStimulus(tbl[v].rst, tbl[v].cap, tbl[v].rdy, tbl[v].base, tbl[v].flags);
      tick();
      checkOutput($sformatf("vec%0d", v), tbl[v].exp);
    end

    // Full-throughput frame: 49 beats, last only on lane 48, then idle
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, BASE_A, 3'b000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, BASE_B, 3'b000);
    for (int i = 0; i < NUM_LANES; i++) begin
      checkOutput($sformatf("full beat %0d", i), beat(BASE_A, i, 3'b000, 1'b0));
      tick();
    end
    checkOutput("full end idle", idleOut(1'b0, 3'b000));

    // Random ready: beats hold while stalled, no loss or duplication
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, BASE_A, 3'b000);
    tick();
    exp_idx   = '0;
    exp_valid = 1'b1;
    checkOutput("rand start", beat(BASE_A, 0, 3'b000, 1'b0));
    cyc = 0;
    while (exp_valid && cyc < 500) begin
      r = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, 1'b0, r, BASE_B, 3'b000);
      tick();
      cyc++;
      if (r) begin
        if (exp_idx == 6'(NUM_LANES - 1)) exp_valid = 1'b0;
        else exp_idx = exp_idx + 6'd1;
      end
      if (exp_valid) checkOutput($sformatf("rand cyc %0d", cyc), beat(BASE_A, int'(exp_idx), 3'b000, 1'b0));
      else checkOutput("rand end idle", idleOut(1'b0, 3'b000));
      if (exp_valid && exp_idx == 6'd10) begin
        checks++;
        if (y_o !== 32'h3F80000A) begin
          failures++;
          $display("[TB] FAIL rand idx10 data: got %h want %h", y_o, 32'h3F80000A);
        end
      end
    end
    if (exp_valid) begin
      checks++;
      failures++;
      $display("[TB] FAIL rand timeout: got still streaming at idx %0d want frame done within 500 cycles", exp_idx);
    end

    // Captures at lanes 20 and 25 mid-stream
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, BASE_A, 3'b000);
    tick();
    for (int i = 0; i < NUM_LANES; i++) begin
      checkOutput($sformatf("midcap beat %0d", i),
                  beat(BASE_A, i, 3'b000, (i == 21) ? !DOUBLE : (i == 26)));
      applyStimulus(1'b0, (i == 20) || (i == 25), 1'b1, BASE_B, 3'b000);
      tick();
    end
`ifdef FIR_OUT_DOUBLE_BUF_EN
    for (int i = 0; i < NUM_LANES; i++) begin
      checkOutput($sformatf("pending beat %0d", i), beat(BASE_B, i, 3'b000, 1'b0));
      tick();
    end
`endif
    checkOutput("midcap end idle", idleOut(1'b0, 3'b000));

    // Sticky flags across the frame, then back-to-back capture on the last handshake
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, BASE_A, 3'b010);
    tick();
    for (int i = 0; i < NUM_LANES; i++) begin
      checkOutput($sformatf("flags beat %0d", i), beat(BASE_A, i, (i <= 5) ? 3'b010 : 3'b110, 1'b0));
      applyStimulus(1'b0, i == NUM_LANES - 1, 1'b1, BASE_B, (i == 5) ? 3'b100 : 3'b000);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b1, BASE_A, 3'b000);
    checkOutput("b2b new frame 0", beat(BASE_B, 0, 3'b000, 1'b0));
    tick();
    checkOutput("b2b new frame 1", beat(BASE_B, 1, 3'b000, 1'b0));

    // Reset in the middle of a frame abandons it
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, BASE_A, 3'b001);
    tick();
    for (int i = 0; i <= 30; i++) begin
      checkOutput($sformatf("rst beat %0d", i), beat(BASE_A, i, 3'b001, 1'b0));
      applyStimulus(i == 30, 1'b0, 1'b1, BASE_B, 3'b000);
      tick();
    end
    checkOutput("rst midframe", idleOut(1'b1, 3'b000));
    applyStimulus(1'b0, 1'b0, 1'b1, BASE_B, 3'b000);
    tick();
    checkOutput("rst no beat after", idleOut(1'b1, 3'b000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
